// File: rtl/leaves_pkg.sv
// Shared defaults, patch type and controller state encoding for the leaf patch memory controller.
package leaves_pkg;

    localparam int unsigned DATA_WIDTH = 11;
    localparam int unsigned PATCH_SIZE = 5;
    localparam int unsigned LEAF_SIZE  = 8;
    localparam int unsigned NUM_LEAVES = 64;

    typedef logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] patch_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        QUERY = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after the pointer.
module rr_arbiter
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
)
(
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] pointer,
    input  logic                advance,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx
);
    import leaves_pkg::*;

    logic found;

    // Scan requesters in rotating order starting just after the pointer.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (advance && !found && req[j] &&
                    (j == ((32'(pointer) + off) % NUM_REQ))) begin
                    found     = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = ID_WIDTH'(j);
                end
            end
        end
    end

endmodule

// File: rtl/leaves_mem_ctrl.sv
// Leaf patch memory controller: packs patches into leaf rows during LOAD and
// arbitrates the single read port among requesters during QUERY.
module leaves_mem_ctrl
#(
    parameter int unsigned DATA_WIDTH = leaves_pkg::DATA_WIDTH,
    parameter int unsigned PATCH_SIZE = leaves_pkg::PATCH_SIZE,
    parameter int unsigned LEAF_SIZE  = leaves_pkg::LEAF_SIZE,
    parameter int unsigned NUM_LEAVES = leaves_pkg::NUM_LEAVES,
    parameter int unsigned ADDR_WIDTH = $clog2(NUM_LEAVES),
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
)
(
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      load_start,
    input  logic                                      patch_valid,
    output logic                                      patch_ready,
    input  logic [PATCH_SIZE*DATA_WIDTH-1:0]          patch_data,
    output logic                                      load_done,
    input  logic [NUM_REQ-1:0]                        req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]             req_leaf,
    output logic [NUM_REQ-1:0]                        req_ready,
    output logic                                      resp_valid,
    output logic [ID_WIDTH-1:0]                       resp_id,
    output logic                                      mem_wen,
    output logic [ADDR_WIDTH-1:0]                     mem_wadr,
    output logic [LEAF_SIZE*PATCH_SIZE*DATA_WIDTH-1:0] mem_wdata,
    output logic                                      mem_ren,
    output logic [ADDR_WIDTH-1:0]                     mem_radr
);
    import leaves_pkg::*;

    localparam int unsigned PW   = PATCH_SIZE * DATA_WIDTH;
    localparam int unsigned PC_W = (LEAF_SIZE > 1) ? $clog2(LEAF_SIZE) : 1;

    ctrl_state_e                     state_q, state_d;
    logic [PC_W-1:0]                 patch_cnt_q, patch_cnt_d;
    logic [ADDR_WIDTH-1:0]           leaf_cnt_q, leaf_cnt_d;
    logic [LEAF_SIZE-1:0][PW-1:0]    buf_q, buf_d, row_next;
    logic [LEAF_SIZE*PW-1:0]         mem_wdata_q, mem_wdata_d;
    logic [ADDR_WIDTH-1:0]           mem_wadr_q, mem_wadr_d;
    logic                            mem_wen_q, mem_wen_d;
    logic                            resp_valid_q, resp_valid_d;
    logic [ID_WIDTH-1:0]             resp_id_q, resp_id_d;
    logic [ID_WIDTH-1:0]             rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0]                 grant;
    logic [ID_WIDTH-1:0]                grant_idx;
    logic                               grant_any;
    logic                               accept;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_leaf_arr;

    assign req_leaf_arr = req_leaf;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req       (req_valid),
        .pointer   (rr_ptr_q),
        .advance   (state_q == QUERY),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign grant_any   = |grant;
    assign patch_ready = (state_q == LOAD);
    assign load_done   = (state_q == QUERY);
    assign accept      = patch_ready & patch_valid & ~load_start;
    assign req_ready   = grant;
    assign mem_ren     = grant_any;
    assign mem_radr    = grant_any ? req_leaf_arr[grant_idx] : '0;
    assign mem_wen     = mem_wen_q;
    assign mem_wadr    = mem_wadr_q;
    assign mem_wdata   = mem_wdata_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;

    // Next-state: load_start overrides any patch handshake in the same cycle.
    always_comb begin
        state_d      = state_q;
        patch_cnt_d  = patch_cnt_q;
        leaf_cnt_d   = leaf_cnt_q;
        buf_d        = buf_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wadr_d   = mem_wadr_q;
        mem_wen_d    = 1'b0;
        resp_valid_d = grant_any;
        resp_id_d    = grant_idx;
        rr_ptr_d     = grant_any ? grant_idx : rr_ptr_q;

        row_next              = buf_q;
        row_next[patch_cnt_q] = patch_data;

        if (load_start) begin
            state_d     = LOAD;
            patch_cnt_d = '0;
            leaf_cnt_d  = '0;
        end else if (accept) begin
            buf_d = row_next;
            if (patch_cnt_q == PC_W'(LEAF_SIZE - 1)) begin
                patch_cnt_d = '0;
                mem_wdata_d = row_next;
                mem_wadr_d  = leaf_cnt_q;
                mem_wen_d   = 1'b1;
                leaf_cnt_d  = leaf_cnt_q + 1'b1;
                if (leaf_cnt_q == ADDR_WIDTH'(NUM_LEAVES - 1)) begin
                    state_d = QUERY;
                end
            end else begin
                patch_cnt_d = patch_cnt_q + 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            patch_cnt_q  <= '0;
            leaf_cnt_q   <= '0;
            buf_q        <= '0;
            mem_wdata_q  <= '0;
            mem_wadr_q   <= '0;
            mem_wen_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            rr_ptr_q     <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            patch_cnt_q  <= patch_cnt_d;
            leaf_cnt_q   <= leaf_cnt_d;
            buf_q        <= buf_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wadr_q   <= mem_wadr_d;
            mem_wen_q    <= mem_wen_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_leaves_mem_ctrl.sv
// Self-checking bench for leaves_mem_ctrl with a behavioural reference model.
module tb_leaves_mem_ctrl;
    import leaves_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = $clog2(NUM_LEAVES);
    localparam int unsigned IDW  = $clog2(NREQ);
    localparam int unsigned PW   = PATCH_SIZE * DATA_WIDTH;
    localparam int unsigned RW   = LEAF_SIZE * PW;
    localparam int unsigned NPAT = NUM_LEAVES * LEAF_SIZE;

    typedef logic [RW-1:0] row_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 load_start;
    logic                 patch_valid;
    logic                 patch_ready;
    logic [PW-1:0]        patch_data;
    logic                 load_done;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_leaf;
    logic [NREQ-1:0]      req_ready;
    logic                 resp_valid;
    logic [IDW-1:0]       resp_id;
    logic                 mem_wen;
    logic [AW-1:0]        mem_wadr;
    logic [RW-1:0]        mem_wdata;
    logic                 mem_ren;
    logic [AW-1:0]        mem_radr;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // query-side model state
    bit          pend [NREQ];
    logic [AW-1:0] lf [NREQ];
    int          last_id;
    bit          prev_v;
    int          prev_id;
    bit          q_active;

    always #5 clk = ~clk;

    leaves_mem_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .PATCH_SIZE (PATCH_SIZE),
        .LEAF_SIZE  (LEAF_SIZE),
        .NUM_LEAVES (NUM_LEAVES),
        .NUM_REQ    (NREQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .patch_valid (patch_valid),
        .patch_ready (patch_ready),
        .patch_data  (patch_data),
        .load_done   (load_done),
        .req_valid   (req_valid),
        .req_leaf    (req_leaf),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .mem_wen     (mem_wen),
        .mem_wadr    (mem_wadr),
        .mem_wdata   (mem_wdata),
        .mem_ren     (mem_ren),
        .mem_radr    (mem_radr)
    );

    task automatic check(input string tag, input row_t got, input row_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic patch_t rep(input int unsigned k);
        patch_t p;
        for (int unsigned e = 0; e < PATCH_SIZE; e++) p[e] = DATA_WIDTH'(k);
        return p;
    endfunction

    function automatic row_t exp_row(input int unsigned r);
        logic [LEAF_SIZE-1:0][PW-1:0] row;
        for (int unsigned i = 0; i < LEAF_SIZE; i++) row[i] = rep(r * LEAF_SIZE + i);
        return row;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_patch_ready"}, row_t'(patch_ready), row_t'(0));
        check({tag, "_load_done"},   row_t'(load_done),   row_t'(0));
        check({tag, "_req_ready"},   row_t'(req_ready),   row_t'(0));
        check({tag, "_resp_valid"},  row_t'(resp_valid),  row_t'(0));
        check({tag, "_resp_id"},     row_t'(resp_id),     row_t'(0));
        check({tag, "_mem_wen"},     row_t'(mem_wen),     row_t'(0));
        check({tag, "_mem_wadr"},    row_t'(mem_wadr),    row_t'(0));
        check({tag, "_mem_wdata"},   mem_wdata,           row_t'(0));
        check({tag, "_mem_ren"},     row_t'(mem_ren),     row_t'(0));
        check({tag, "_mem_radr"},    row_t'(mem_radr),    row_t'(0));
    endtask

    // Streams n_total patches (patch k = k in every element) and checks every row write.
    task automatic load_run(input bit do_start, input bit rnd, input int unsigned n_total);
        int unsigned acc = 0;
        int unsigned cyc = 0;
        int unsigned nw = 0;
        int unsigned last_w = 0;
        bit          have_last = 0;
        bit          wen_exp = 0;
        bit          wen_next;
        int unsigned wadr_exp = 0;
        bit          loading = 1;
        bit          done_exp = 0;
        bit          v;
        req_valid = '0;
        if (do_start) begin
            load_start  = 1'b1;
            patch_valid = 1'b1;
            patch_data  = PW'({$urandom, $urandom});
            @(posedge clk); #1;
            load_start  = 1'b0;
        end
        while ((acc < n_total || wen_exp) && cyc < 4000) begin
            v = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
            if (loading && acc >= n_total) v = 1'b0;
            patch_valid = v;
            patch_data  = v ? PW'(rep(acc)) : PW'({$urandom, $urandom});
            @(negedge clk);
            check("patch_ready", row_t'(patch_ready), row_t'(loading));
            check("mem_wen", row_t'(mem_wen), row_t'(wen_exp));
            check("load_done", row_t'(load_done), row_t'(done_exp));
            if (wen_exp) begin
                check("mem_wadr", row_t'(mem_wadr), row_t'(wadr_exp));
                check("mem_wdata", mem_wdata, exp_row(wadr_exp));
                if (have_last && !rnd) check("wen_gap", row_t'(cyc - last_w), row_t'(LEAF_SIZE));
                last_w    = cyc;
                have_last = 1'b1;
                nw++;
            end
            wen_next = 1'b0;
            if (v && loading) begin
                acc++;
                if (acc % LEAF_SIZE == 0) begin
                    wen_next = 1'b1;
                    wadr_exp = acc / LEAF_SIZE - 1;
                end
                if (acc == NPAT) begin
                    loading  = 1'b0;
                    done_exp = 1'b1;
                end
            end
            wen_exp = wen_next;
            @(posedge clk); #1;
            cyc++;
        end
        patch_valid = 1'b0;
        if (cyc >= 4000) check("load_timeout", row_t'(0), row_t'(1));
        check("write_count", row_t'(nw), row_t'(n_total / LEAF_SIZE));
    endtask

    // One QUERY-phase cycle checked against the round-robin rule.
    task automatic q_cycle(input bit ls);
        int g = -1;
        logic [NREQ-1:0] exp_rdy = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = pend[i];
            req_leaf[i*AW +: AW]  = lf[i];
        end
        load_start = ls;
        @(negedge clk);
        if (q_active) begin
            for (int off = 1; off <= NREQ; off++) begin
                int c;
                c = (last_id + off) % NREQ;
                if (g < 0 && pend[c]) g = c;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", row_t'(req_ready), row_t'(exp_rdy));
        check("mem_ren", row_t'(mem_ren), row_t'(g >= 0));
        if (g >= 0) check("mem_radr", row_t'(mem_radr), row_t'(lf[g]));
        check("resp_valid", row_t'(resp_valid), row_t'(prev_v));
        if (prev_v) check("resp_id", row_t'(resp_id), row_t'(prev_id));
        check("q_load_done", row_t'(load_done), row_t'(q_active));
        prev_v = (g >= 0);
        if (g >= 0) begin
            prev_id = g;
            last_id = g;
            pend[g] = 1'b0;
        end
        if (ls) q_active = 1'b0;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        load_start  = 1'b0;
        patch_valid = 1'b0;
        patch_data  = '0;
        req_valid   = '1;
        req_leaf    = '0;
        for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; lf[i] = '0; end
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        last_id   = NREQ - 1;
        prev_v    = 1'b0;
        prev_id   = 0;
        q_active  = 1'b0;

        // full load, back-to-back patches
        load_run(1'b1, 1'b0, NPAT);
        q_active = 1'b1;

        // full reload from QUERY with gappy patch_valid
        load_run(1'b1, 1'b1, NPAT);
        q_active = 1'b1;
        prev_v   = 1'b0;

        // all requesters valid, leaves 3/7/11/15
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b1; lf[i] = AW'(4 * i + 3); end
            q_cycle(1'b0);
        end

        // only requester 2
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
            pend[2] = 1'b1;
            lf[2]   = AW'(9);
            q_cycle(1'b0);
        end

        // random held requests
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    lf[i]   = AW'($urandom_range(0, NUM_LEAVES - 1));
                end
            end
            q_cycle(1'b0);
        end

        // load_start while a read is being granted
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        pend[1] = 1'b1;
        lf[1]   = AW'(42);
        q_cycle(1'b1);
        pend[1] = 1'b1;
        q_cycle(1'b0);
        pend[1] = 1'b0;
        q_cycle(1'b0);
        req_valid = '0;
        load_run(1'b0, 1'b0, 2 * LEAF_SIZE);

        // reset in the middle of a partial row
        load_run(1'b1, 1'b0, 20);
        rst         = 1'b1;
        patch_valid = 1'b1;
        patch_data  = PW'({$urandom, $urandom});
        req_valid   = '1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk); #1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("post_rst_wen", row_t'(mem_wen), row_t'(0));
            check("post_rst_ready", row_t'(patch_ready), row_t'(0));
            @(posedge clk); #1;
        end
        patch_valid = 1'b0;
        req_valid   = '0;
        load_run(1'b1, 1'b0, 2 * LEAF_SIZE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
